// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions: exception cause codes, exception FSM
// state encoding and the default location of the source-enable mask bits.
package cpu_ctrl_pkg;

   localparam int EX_INPUT      = 0;
   localparam int EX_OVFL       = 1;
   localparam int EX_ACCINV     = 2;
   localparam int EX_MISALIGN   = 3;

   localparam int MASK_BASE_DEF = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      EX_B   = 3'd1,
      EX_PC  = 3'd2,
      EX_ALU = 3'd3,
      EX_WB  = 3'd4,
      HALT   = 3'd5
   } exState_t;

endpackage

// File: rtl/ex_priority_enc.sv
// Lowest-index-wins encoder: reports whether any request is set, the
// winning index and the winner as a one-hot vector.
module ex_priority_enc #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] reqVec,
   output logic         anyValid,
   output logic [W-1:0] index,
   output logic [N-1:0] oneHot
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      anyValid = |reqVec;
      index    = '0;
      oneHot   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (reqVec[i]) begin
            index     = W'(i);
            oneHot    = '0;
            oneHot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/exception_sequencer.sv
// Exception/interrupt unit for the multicycle control path. Picks a cause
// from the sync faults and pending async requests, then walks the entry
// micro-sequence (save B, vector PC, handler ALU, writeback) one step per
// cycle while the main controller is held.
import cpu_ctrl_pkg::*;

module exception_sequencer #(
   parameter int               N_SRC     = 4,
   parameter int               CAUSE_W   = 2,
   parameter int               SR_W      = 16,
   parameter int               MASK_BASE = MASK_BASE_DEF,
   parameter logic [N_SRC-1:0] SYNC_MASK = 4'b1110
) (
   input  logic               CLK,
   input  logic               Reset_n,
   input  logic [N_SRC-1:0]   SrcReq,
   input  logic               FaultCheck,
   input  logic               Boundary,
   input  logic               ExReturn,
   input  logic [SR_W-1:0]    Status,
   output logic               ExActive,
   output logic               ExDismiss,
   output logic               ExDone,
   output logic [CAUSE_W-1:0] ExType,
   output logic               StepB,
   output logic               StepPC,
   output logic               StepALU,
   output logic               StepWB,
   output logic               KernelMode,
   output logic               Halted
);

   exState_t             state, stateNext;
   logic [N_SRC-1:0]     pending, enable;
   logic [N_SRC-1:0]     syncVec, asyncVec, syncOneHot, asyncOneHot;
   logic                 syncAny, asyncAny;
   logic [CAUSE_W-1:0]   syncIdx, asyncIdx;
   logic                 take, takeAsync;
   logic                 unusedStatus;

   // Only the mask field of the status register matters here; the rest
   // belongs to other units.
   assign unusedStatus = &{1'b0, Status};

   // Pull the per-source enable bits out of the status register.
   always_comb begin
      enable = '0;
      for (int i = 0; i < N_SRC; i++) enable[i] = Status[MASK_BASE + i];
   end

   // Sync faults only count while the controller is in a fault-capable
   // state; the winner is chosen before the mask so a masked low-index
   // fault is dismissed rather than letting a higher one through.
   assign syncVec  = SrcReq & SYNC_MASK & {N_SRC{FaultCheck}};
   assign asyncVec = pending & enable & ~SYNC_MASK;

   ex_priority_enc #(.N(N_SRC), .W(CAUSE_W)) uSyncEnc (
      .reqVec(syncVec), .anyValid(syncAny), .index(syncIdx), .oneHot(syncOneHot)
   );

   ex_priority_enc #(.N(N_SRC), .W(CAUSE_W)) uAsyncEnc (
      .reqVec(asyncVec), .anyValid(asyncAny), .index(asyncIdx), .oneHot(asyncOneHot)
   );

   // Next-state and take decision; sync faults pre-empt async requests, and
   // a return-from-exception defers an async take to the next boundary.
   always_comb begin
      stateNext = state;
      ExDismiss = 1'b0;
      take      = 1'b0;
      takeAsync = 1'b0;
      case (state)
         IDLE: begin
            if (syncAny) begin
               if (|(syncOneHot & enable)) begin
                  take      = 1'b1;
                  stateNext = KernelMode ? HALT : EX_B;
               end else begin
                  ExDismiss = 1'b1;
               end
            end else if (Boundary && asyncAny && !KernelMode && !ExReturn) begin
               take      = 1'b1;
               takeAsync = 1'b1;
               stateNext = EX_B;
            end
         end
         EX_B:    stateNext = EX_PC;
         EX_PC:   stateNext = EX_ALU;
         EX_ALU:  stateNext = EX_WB;
         EX_WB:   stateNext = IDLE;
         HALT:    stateNext = HALT;
         default: stateNext = IDLE;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= stateNext;
   end

   // Async requests stay pending until they are actually taken.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) pending <= '0;
      else          pending <= (pending & ~(takeAsync ? asyncOneHot : '0))
                               | (SrcReq & ~SYNC_MASK);
   end

   // Cause is captured on the take edge and held until the next take.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n)  ExType <= '0;
      else if (take) ExType <= syncAny ? syncIdx : asyncIdx;
   end

   // Kernel mode is entered with the sequence and left on return from IDLE.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n)                       KernelMode <= 1'b0;
      else if (take && stateNext == EX_B) KernelMode <= 1'b1;
      else if (state == IDLE && ExReturn) KernelMode <= 1'b0;
   end

   assign StepB    = (state == EX_B);
   assign StepPC   = (state == EX_PC);
   assign StepALU  = (state == EX_ALU);
   assign StepWB   = (state == EX_WB);
   assign ExDone   = (state == EX_WB);
   assign Halted   = (state == HALT);
   assign ExActive = (state != IDLE);

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: a cycle-by-cycle vector table for
// the main take/mask/async/priority flows, then hand-written sequences for
// double fault and reset in the middle of an entry sequence.
module tb_exception_sequencer;

   logic        CLK = 1'b0;
   logic        Reset_n;
   logic [3:0]  SrcReq;
   logic        FaultCheck, Boundary, ExReturn;
   logic [15:0] Status;
   logic        ExActive, ExDismiss, ExDone, StepB, StepPC, StepALU, StepWB;
   logic        KernelMode, Halted;
   logic [1:0]  ExType;

   int nCompared = 0;
   int nFailed   = 0;

   exception_sequencer dut (
      .CLK(CLK), .Reset_n(Reset_n), .SrcReq(SrcReq), .FaultCheck(FaultCheck),
      .Boundary(Boundary), .ExReturn(ExReturn), .Status(Status),
      .ExActive(ExActive), .ExDismiss(ExDismiss), .ExDone(ExDone), .ExType(ExType),
      .StepB(StepB), .StepPC(StepPC), .StepALU(StepALU), .StepWB(StepWB),
      .KernelMode(KernelMode), .Halted(Halted)
   );

   always #5 CLK = ~CLK;

   // {act, dismiss, done, type[1:0], B, PC, ALU, WB, kernel, halted}
   logic [10:0] outVec;
   assign outVec = {ExActive, ExDismiss, ExDone, ExType, StepB, StepPC, StepALU, StepWB,
                    KernelMode, Halted};

   typedef struct {
      logic [3:0]  src;
      logic        fc, bd, ret;
      logic [15:0] st;
      logic [10:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [10:0] o(input logic act, dis, done, input logic [1:0] typ,
                                     input logic [3:0] steps, input logic km, h);
      return {act, dis, done, typ, steps, km, h};
   endfunction

   task automatic add(input logic [3:0] src, input logic fc, bd, ret, input logic [15:0] st,
                      input logic [10:0] exp);
      vec_t v;
      v.src = src; v.fc = fc; v.bd = bd; v.ret = ret; v.st = st; v.exp = exp;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [10:0] exp);
      nCompared++;
      if (outVec !== exp) begin
         nFailed++;
         $display("FAIL %s: got %b want %b (act dis done type BPCALUWB km halt)",
                  name, outVec, exp);
      end
   endtask

   task automatic drive(input logic [3:0] src, input logic fc, bd, ret, input logic [15:0] st);
      @(posedge CLK);
      #1;
      SrcReq = src; FaultCheck = fc; Boundary = bd; ExReturn = ret; Status = st;
   endtask

   initial begin
      Reset_n = 1'b0;
      SrcReq = '0; FaultCheck = 0; Boundary = 0; ExReturn = 0; Status = '0;
      #3;
      chk("reset_state", o(0,0,0,2'd0,4'b0000,0,0));
      #9 Reset_n = 1'b1;

      // ovfl take, enabled
      add(4'h0,0,0,0,16'h00F0, o(0,0,0,2'd0,4'b0000,0,0));
      add(4'h2,1,0,0,16'h0020, o(0,0,0,2'd0,4'b0000,0,0));
      add(4'h0,0,0,0,16'h0020, o(1,0,0,2'd1,4'b1000,1,0));
      add(4'h0,0,0,0,16'h0020, o(1,0,0,2'd1,4'b0100,1,0));
      add(4'h0,0,0,0,16'h0020, o(1,0,0,2'd1,4'b0010,1,0));
      add(4'h0,0,0,0,16'h0020, o(1,0,1,2'd1,4'b0001,1,0));
      add(4'h0,0,0,0,16'h0020, o(0,0,0,2'd1,4'b0000,1,0));
      add(4'h0,0,0,1,16'h0020, o(0,0,0,2'd1,4'b0000,1,0));
      add(4'h0,0,0,0,16'h0020, o(0,0,0,2'd1,4'b0000,0,0));
      // ovfl masked -> dismiss, no sequence
      add(4'h2,1,0,0,16'h0000, o(0,1,0,2'd1,4'b0000,0,0));
      add(4'h0,0,0,0,16'h0000, o(0,0,0,2'd1,4'b0000,0,0));
      // async src0 pulse, boundary six cycles later
      add(4'h1,0,0,0,16'h0010, o(0,0,0,2'd1,4'b0000,0,0));
      for (int i = 0; i < 5; i++)
         add(4'h0,0,0,0,16'h0010, o(0,0,0,2'd1,4'b0000,0,0));
      add(4'h0,0,1,0,16'h0010, o(0,0,0,2'd1,4'b0000,0,0));
      add(4'h0,0,0,0,16'h0010, o(1,0,0,2'd0,4'b1000,1,0));
      add(4'h0,0,0,0,16'h0010, o(1,0,0,2'd0,4'b0100,1,0));
      add(4'h0,0,0,0,16'h0010, o(1,0,0,2'd0,4'b0010,1,0));
      add(4'h0,0,0,0,16'h0010, o(1,0,1,2'd0,4'b0001,1,0));
      add(4'h0,0,0,1,16'h0010, o(0,0,0,2'd0,4'b0000,1,0));
      // pending was cleared: boundary takes nothing
      add(4'h0,0,1,0,16'h00F0, o(0,0,0,2'd0,4'b0000,0,0));
      add(4'h0,0,0,0,16'h00F0, o(0,0,0,2'd0,4'b0000,0,0));
      // priority: sync src2 beats src3 and async src0
      add(4'hD,1,1,0,16'h00F0, o(0,0,0,2'd0,4'b0000,0,0));
      add(4'h0,0,0,0,16'h00F0, o(1,0,0,2'd2,4'b1000,1,0));
      add(4'h8,1,0,0,16'h00F0, o(1,0,0,2'd2,4'b0100,1,0));
      add(4'h0,0,0,0,16'h00F0, o(1,0,0,2'd2,4'b0010,1,0));
      add(4'h0,0,0,0,16'h00F0, o(1,0,1,2'd2,4'b0001,1,0));
      add(4'h0,0,0,1,16'h00F0, o(0,0,0,2'd2,4'b0000,1,0));
      // return beats async take at the same boundary; next boundary takes src0
      add(4'h0,0,1,1,16'h00F0, o(0,0,0,2'd2,4'b0000,0,0));
      add(4'h0,0,1,0,16'h00F0, o(0,0,0,2'd2,4'b0000,0,0));
      add(4'h0,0,0,0,16'h00F0, o(1,0,0,2'd0,4'b1000,1,0));
      add(4'h0,0,0,0,16'h00F0, o(1,0,0,2'd0,4'b0100,1,0));
      add(4'h0,0,0,0,16'h00F0, o(1,0,0,2'd0,4'b0010,1,0));
      add(4'h0,0,0,0,16'h00F0, o(1,0,1,2'd0,4'b0001,1,0));
      add(4'h0,0,0,0,16'h00F0, o(0,0,0,2'd0,4'b0000,1,0));

      foreach (tbl[k]) begin
         drive(tbl[k].src, tbl[k].fc, tbl[k].bd, tbl[k].ret, tbl[k].st);
         @(negedge CLK);
         chk($sformatf("vec[%0d]", k), tbl[k].exp);
      end

      // double fault: misalign while still in kernel mode
      drive(4'h8,1,0,0,16'h00F0);
      @(negedge CLK); chk("df_take", o(0,0,0,2'd0,4'b0000,1,0));
      drive(4'h0,0,0,0,16'h00F0);
      @(negedge CLK); chk("df_halt", o(1,0,0,2'd3,4'b0000,1,1));
      for (int i = 0; i < 3; i++) begin
         drive(4'hF,1,1,1,16'h00F0);
         @(negedge CLK); chk($sformatf("df_sticky%0d", i), o(1,0,0,2'd3,4'b0000,1,1));
      end
      SrcReq = '0; FaultCheck = 0; Boundary = 0; ExReturn = 0;
      #2 Reset_n = 1'b0;
      #1 chk("df_reset", o(0,0,0,2'd0,4'b0000,0,0));
      @(negedge CLK) Reset_n = 1'b1;

      // reset in the middle of an entry sequence
      drive(4'h2,1,0,0,16'h0020);
      @(negedge CLK); chk("mid_take", o(0,0,0,2'd0,4'b0000,0,0));
      drive(4'h0,0,0,0,16'h0020);
      @(negedge CLK); chk("mid_exb", o(1,0,0,2'd1,4'b1000,1,0));
      drive(4'h0,0,0,0,16'h0020);
      @(negedge CLK); chk("mid_expc", o(1,0,0,2'd1,4'b0100,1,0));
      #1 Reset_n = 1'b0;
      #1 chk("mid_reset_async", o(0,0,0,2'd0,4'b0000,0,0));
      @(negedge CLK); chk("mid_reset_held", o(0,0,0,2'd0,4'b0000,0,0));
      Reset_n = 1'b1;
      @(negedge CLK); chk("mid_after_rel0", o(0,0,0,2'd0,4'b0000,0,0));
      @(negedge CLK); chk("mid_after_rel1", o(0,0,0,2'd0,4'b0000,0,0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end

endmodule
